// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding and default frame parameters.
// The transmitter imports this package too.
package uart_pkg;

   localparam int unsigned UART_DATA_BITS       = 8;
   localparam int unsigned UART_DEFAULT_DIVISOR = 16;

   typedef enum logic [2:0] {
      StIdle,
      StStart,
      StData,
      StStop,
      StWaitIdle
   } uart_rx_state_t;

endpackage

// File: rtl/uart_rx_fifo.sv
// Small synchronous FIFO for received bytes.
// A full FIFO still accepts an enqueue when a dequeue fires in the same cycle.
module uart_rx_fifo #(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned DEPTH = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             enq_valid,
   output logic             enq_ready,
   input  logic [WIDTH-1:0] enq_bits,
   output logic             deq_valid,
   input  logic             deq_ready,
   output logic [WIDTH-1:0] deq_bits,
   output logic             full,
   output logic             empty
);

   localparam int unsigned AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wptr;
   logic [AW-1:0]    rptr;
   logic [AW:0]      count;
   logic             enq_fire;
   logic             deq_fire;

   assign full      = (count == (AW + 1)'(DEPTH));
   assign empty     = (count == '0);
   assign enq_ready = !full || deq_ready;
   assign deq_valid = !empty;
   assign deq_bits  = empty ? '0 : mem[rptr];
   assign enq_fire  = enq_valid && enq_ready;
   assign deq_fire  = deq_valid && deq_ready;

   always_ff @(posedge clk) begin
      if (enq_fire) begin
         mem[wptr] <= enq_bits;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wptr  <= '0;
         rptr  <= '0;
         count <= '0;
      end else begin
         if (enq_fire) begin
            wptr <= wptr + 1'b1;
         end
         if (deq_fire) begin
            rptr <= rptr + 1'b1;
         end
         case ({enq_fire, deq_fire})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver: two-flop synchronizer, mid-bit sampling framing FSM and a
// receive FIFO with a ready/valid dequeue port.
module uart_rx
   import uart_pkg::*;
#(
   parameter int unsigned DIVISOR    = UART_DEFAULT_DIVISOR,
   parameter int unsigned DATA_BITS  = UART_DATA_BITS,
   parameter int unsigned FIFO_DEPTH = 4
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 io_pins_rxd,
   input  logic                 io_ctl_deq_ready,
   output logic                 io_ctl_deq_valid,
   output logic [DATA_BITS-1:0] io_ctl_deq_bits,
   output logic                 io_frame_err,
   output logic                 io_overrun
);

   localparam int unsigned CNT_W = $clog2(DIVISOR);
   localparam int unsigned IDX_W = $clog2(DATA_BITS);
   localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(DIVISOR / 2 - 1);
   localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DIVISOR - 1);
   localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_BITS - 1);

   uart_rx_state_t       state;
   uart_rx_state_t       state_next;
   logic                 rxd_meta;
   logic                 rxd_s;
   logic [CNT_W-1:0]     cnt;
   logic [IDX_W-1:0]     bit_idx;
   logic [DATA_BITS-1:0] shift;
   logic                 cnt_zero;
   logic                 push;
   logic                 frame_err_set;
   logic                 fifo_enq_ready;
   logic                 fifo_full;
   logic                 fifo_empty;

   assign cnt_zero = (cnt == '0);

   // Line idles high, so the synchronizer resets to 1 to avoid a fake start bit.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rxd_meta <= 1'b1;
         rxd_s    <= 1'b1;
      end else begin
         rxd_meta <= io_pins_rxd;
         rxd_s    <= rxd_meta;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= StIdle;
      end else begin
         state <= state_next;
      end
   end

   always_comb begin
      state_next = state;
      unique case (state)
         StIdle:     if (!rxd_s) state_next = StStart;
         StStart:    if (cnt_zero) state_next = rxd_s ? StIdle : StData;
         StData:     if (cnt_zero && (bit_idx == IDX_LAST)) state_next = StStop;
         StStop:     if (cnt_zero) state_next = rxd_s ? StIdle : StWaitIdle;
         StWaitIdle: if (rxd_s) state_next = StIdle;
         default:    state_next = StIdle;
      endcase
   end

   always_comb begin
      push          = 1'b0;
      frame_err_set = 1'b0;
      if ((state == StStop) && cnt_zero) begin
         push          = rxd_s;
         frame_err_set = !rxd_s;
      end
   end

   // Idle reloads the half-bit count every cycle so a start edge needs no extra setup.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cnt     <= CNT_HALF;
         bit_idx <= '0;
         shift   <= '0;
      end else begin
         unique case (state)
            StStart, StData, StStop: begin
               cnt <= cnt_zero ? CNT_FULL : cnt - 1'b1;
               if (cnt_zero && (state == StStart)) begin
                  bit_idx <= '0;
               end
               if (cnt_zero && (state == StData)) begin
                  shift   <= {rxd_s, shift[DATA_BITS-1:1]};
                  bit_idx <= bit_idx + 1'b1;
               end
            end
            default: cnt <= CNT_HALF;
         endcase
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         io_frame_err <= 1'b0;
         io_overrun   <= 1'b0;
      end else begin
         io_frame_err <= frame_err_set;
         io_overrun   <= push && !fifo_enq_ready;
      end
   end

   uart_rx_fifo #(
      .WIDTH (DATA_BITS),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk       (clk),
      .reset     (reset),
      .enq_valid (push),
      .enq_ready (fifo_enq_ready),
      .enq_bits  (shift),
      .deq_valid (io_ctl_deq_valid),
      .deq_ready (io_ctl_deq_ready),
      .deq_bits  (io_ctl_deq_bits),
      .full      (fifo_full),
      .empty     (fifo_empty)
   );

   fifo_flags_exclusive : assert property (@(posedge clk) disable iff (reset)
      !(fifo_full && fifo_empty));

endmodule

// File: tb/tb_uart_rx.sv
// Bench for uart_rx: serial frames driven on the pin, expected bytes queued at
// send time and compared as the consumer dequeues them.
module tb_uart_rx;

   localparam int unsigned DIV = 16;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       rxd = 1'b1;
   logic       deq_ready = 1'b0;
   logic       deq_valid;
   logic [7:0] deq_bits;
   logic       frame_err;
   logic       overrun;

   int unsigned cyc = 0;
   int unsigned frame_cyc = 0;
   int unsigned valid_rise_cyc = 0;
   int          n_checks = 0;
   int          n_fail = 0;
   int          ferr_cnt = 0;
   int          ovr_cnt = 0;
   int          f0;
   int          o0;
   logic        prev_valid = 1'b0;
   logic        abort = 1'b0;
   logic [7:0]  exp_q[$];

   uart_rx #(
      .DIVISOR    (DIV),
      .DATA_BITS  (8),
      .FIFO_DEPTH (4)
   ) dut (
      .clk              (clk),
      .reset            (reset),
      .io_pins_rxd      (rxd),
      .io_ctl_deq_ready (deq_ready),
      .io_ctl_deq_valid (deq_valid),
      .io_ctl_deq_bits  (deq_bits),
      .io_frame_err     (frame_err),
      .io_overrun       (overrun)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
      end
   endtask

   // Consumer side: count error pulses, pop the scoreboard on each dequeue.
   initial begin
      forever begin
         @(negedge clk);
         #1;
         if (reset) begin
            prev_valid = 1'b0;
         end else begin
            if (frame_err) ferr_cnt++;
            if (overrun) ovr_cnt++;
            if (deq_valid && !prev_valid) valid_rise_cyc = cyc;
            prev_valid = deq_valid;
            if (deq_valid && deq_ready) begin
               if (exp_q.size() == 0) check_eq("deq_extra", 32'(exp_q.size()), 32'd1);
               else check_eq("deq", 32'(deq_bits), 32'(exp_q.pop_front()));
            end
         end
      end
   end

   task automatic idle(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic hold(input logic b, input int n);
      rxd = abort ? 1'b1 : b;
      for (int i = 0; i < n && !abort; i++) @(negedge clk);
      if (abort) rxd = 1'b1;
   endtask

   // Called on a negedge; returns on a negedge so frames can run back to back.
   task automatic send_frame(input logic [7:0] data, input int stop_low);
      frame_cyc = cyc;
      hold(1'b0, DIV);
      for (int i = 0; i < 8; i++) hold(data[i], DIV);
      if (stop_low > 0) begin
         hold(1'b0, stop_low);
         hold(1'b1, DIV);
      end else begin
         hold(1'b1, DIV);
      end
   endtask

   task automatic wait_drain(input string tag);
      for (int i = 0; i < 3000 && exp_q.size() != 0; i++) @(negedge clk);
      idle(2);
      check_eq(tag, 32'(exp_q.size()), 32'd0);
   endtask

   initial begin
      idle(3);
      check_eq("rst_valid", 32'(deq_valid), 32'd0);
      check_eq("rst_bits", 32'(deq_bits), 32'd0);
      check_eq("rst_ferr", 32'(frame_err), 32'd0);
      check_eq("rst_ovr", 32'(overrun), 32'd0);
      reset = 1'b0;

      idle(200);
      check_eq("idle_valid", 32'(deq_valid), 32'd0);
      check_eq("idle_ferr", 32'(ferr_cnt), 32'd0);
      check_eq("idle_ovr", 32'(ovr_cnt), 32'd0);

      deq_ready = 1'b1;
      exp_q.push_back(8'hFE);
      send_frame(8'hFE, 0);
      idle(20);
      wait_drain("drain_fe");
      check_eq("latency", valid_rise_cyc - frame_cyc, 32'd155);

      f0 = ferr_cnt;
      rxd = 1'b0;
      idle(4);
      rxd = 1'b1;
      idle(40);
      check_eq("glitch_ferr", 32'(ferr_cnt - f0), 32'd0);
      check_eq("glitch_valid", 32'(deq_valid), 32'd0);
      exp_q.push_back(8'hA5);
      send_frame(8'hA5, 0);
      idle(20);
      wait_drain("drain_a5");

      f0 = ferr_cnt;
      send_frame(8'h3C, 40);
      idle(20);
      check_eq("break_ferr", 32'(ferr_cnt - f0), 32'd1);
      check_eq("break_valid", 32'(deq_valid), 32'd0);
      exp_q.push_back(8'h55);
      send_frame(8'h55, 0);
      idle(20);
      wait_drain("drain_55");

      deq_ready = 1'b0;
      o0 = ovr_cnt;
      for (int k = 1; k <= 4; k++) exp_q.push_back(8'(k));
      for (int k = 1; k <= 5; k++) send_frame(8'(k), 0);
      idle(20);
      check_eq("ovr_pulse", 32'(ovr_cnt - o0), 32'd1);
      check_eq("ovr_head", 32'(deq_bits), 32'h01);
      check_eq("ovr_valid", 32'(deq_valid), 32'd1);
      deq_ready = 1'b1;
      wait_drain("drain_ovr");

      // Fill the FIFO, then raise ready exactly on the cycle the fifth byte is pushed.
      deq_ready = 1'b0;
      for (int k = 0; k < 4; k++) begin
         exp_q.push_back(8'h81 + 8'(k));
         send_frame(8'h81 + 8'(k), 0);
      end
      idle(10);
      o0 = ovr_cnt;
      exp_q.push_back(8'h85);
      fork
         send_frame(8'h85, 0);
         begin
            repeat (154) @(negedge clk);
            deq_ready = 1'b1;
         end
      join
      idle(20);
      check_eq("coinc_ovr", 32'(ovr_cnt - o0), 32'd0);
      wait_drain("drain_coinc");

      deq_ready = 1'b0;
      send_frame(8'h11, 0);
      idle(5);
      check_eq("pre_rst_valid", 32'(deq_valid), 32'd1);
      f0 = ferr_cnt;
      o0 = ovr_cnt;
      fork
         send_frame(8'h22, 0);
         begin
            repeat (60) @(negedge clk);
            reset = 1'b1;
            #1;
            check_eq("mid_rst_valid", 32'(deq_valid), 32'd0);
            check_eq("mid_rst_bits", 32'(deq_bits), 32'd0);
            @(negedge clk);
            abort = 1'b1;
            repeat (3) @(negedge clk);
            reset = 1'b0;
         end
      join
      abort = 1'b0;
      rxd = 1'b1;
      idle(40);
      check_eq("post_rst_err", 32'(ferr_cnt - f0 + ovr_cnt - o0), 32'd0);
      check_eq("post_rst_valid", 32'(deq_valid), 32'd0);
      deq_ready = 1'b1;
      exp_q.push_back(8'h7E);
      send_frame(8'h7E, 0);
      idle(20);
      wait_drain("drain_7e");

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
